// File: rtl/irq_src.sv
// Interrupt source: CLINT-style mtime/mtimecmp timer, software interrupt bit and
// synchronized external lines behind a single-cycle register bus. Edge-latched lines need IRQ_SRC_EDGE_EN.
module irq_src #(
  parameter int NUM_EXT     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE    = 1,
  parameter int RSZ         = 32
) (
  input  logic               clk_in,
  input  logic               reset_n_in,
  input  logic [NUM_EXT-1:0] ext_irq_in,
  input  logic               bus_wr,
  input  logic               bus_rd,
  input  logic [2:0]         bus_addr,
  input  logic [RSZ-1:0]     bus_wdata,
  output logic [RSZ-1:0]     bus_rdata,
  output logic               bus_ack,
  output logic               msip,
  output logic               mtip,
  output logic               meip,
  output logic               ext_irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PONE = PW'(1);
  localparam logic [2*RSZ-1:0] TONE = (2*RSZ)'(1);

  logic [PW-1:0]                    r_presc;
  logic [2*RSZ-1:0]                 r_mtime;
  logic [2*RSZ-1:0]                 r_mtimecmp;
  logic                             r_msip;
  logic                             r_mtip;
  logic                             r_meip;
  logic [NUM_EXT-1:0]               r_ext_en;
  logic [NUM_EXT-1:0]               r_ext_pend;
  logic [SYNC_STAGES-1:0][NUM_EXT-1:0] r_sync;
  logic [RSZ-1:0]                   r_rdata;
  logic                             r_ack;

  logic                             w_tick;
  logic [7:0]                       w_wsel;
  logic [NUM_EXT-1:0]               w_sync;
  logic [NUM_EXT-1:0]               w_pend_nxt;
  logic [NUM_EXT-1:0]               w_ext_mode;
  logic [RSZ-1:0]                   w_rdata;

  assign w_tick = (r_presc == PMAX);
  assign w_wsel = bus_wr ? (8'd1 << bus_addr) : 8'd0;
  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PONE;
    end
  end

  // A write to either half wins over the tick in the same cycle.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_mtime <= '0;
    end else if (w_wsel[0]) begin
      r_mtime[RSZ-1:0] <= bus_wdata;
    end else if (w_wsel[1]) begin
      r_mtime[2*RSZ-1:RSZ] <= bus_wdata;
    end else if (w_tick) begin
      r_mtime <= r_mtime + TONE;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_mtimecmp <= '1;
      r_msip     <= 1'b0;
      r_ext_en   <= '0;
      r_mtip     <= 1'b0;
    end else begin
      if (w_wsel[2]) r_mtimecmp[RSZ-1:0]       <= bus_wdata;
      if (w_wsel[3]) r_mtimecmp[2*RSZ-1:RSZ]   <= bus_wdata;
      if (w_wsel[4]) r_msip                    <= bus_wdata[0];
      if (w_wsel[5]) r_ext_en                  <= bus_wdata[NUM_EXT-1:0];
      r_mtip <= (r_mtime >= r_mtimecmp);
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= ext_irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

`ifdef IRQ_SRC_EDGE_EN
  logic [NUM_EXT-1:0] r_ext_mode;
  logic [NUM_EXT-1:0] r_sync_d;
  logic [NUM_EXT-1:0] w_rise;
  logic [NUM_EXT-1:0] w_w1c;

  // Edge lines: a new rising edge beats a simultaneous W1C.
  assign w_rise     = w_sync & ~r_sync_d;
  assign w_w1c      = w_wsel[6] ? bus_wdata[NUM_EXT-1:0] : '0;
  assign w_pend_nxt = (r_ext_mode & (w_rise | (r_ext_pend & ~w_w1c))) |
                      (~r_ext_mode & w_sync);
  assign w_ext_mode = r_ext_mode;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_ext_mode <= '0;
      r_sync_d   <= '0;
    end else begin
      if (w_wsel[7]) r_ext_mode <= bus_wdata[NUM_EXT-1:0];
      r_sync_d <= w_sync;
    end
  end
`else
  assign w_pend_nxt = w_sync;
  assign w_ext_mode = '0;
`endif

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_ext_pend <= '0;
      r_meip     <= 1'b0;
    end else begin
      r_ext_pend <= w_pend_nxt;
      r_meip     <= |(r_ext_pend & r_ext_en);
    end
  end

  // Read mux sees pre-write state, so a combined rd+wr returns the old value.
  always_comb begin
    w_rdata = '0;
    case (bus_addr)
      3'd0:    w_rdata = r_mtime[RSZ-1:0];
      3'd1:    w_rdata = r_mtime[2*RSZ-1:RSZ];
      3'd2:    w_rdata = r_mtimecmp[RSZ-1:0];
      3'd3:    w_rdata = r_mtimecmp[2*RSZ-1:RSZ];
      3'd4:    w_rdata[0] = r_msip;
      3'd5:    w_rdata[NUM_EXT-1:0] = r_ext_en;
      3'd6:    w_rdata[NUM_EXT-1:0] = r_ext_pend;
      3'd7:    w_rdata[NUM_EXT-1:0] = w_ext_mode;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_rdata <= '0;
      r_ack   <= 1'b0;
    end else begin
      if (bus_rd) r_rdata <= w_rdata;
      r_ack <= bus_wr | bus_rd;
    end
  end

  assign bus_rdata = r_rdata;
  assign bus_ack   = r_ack;
  assign msip      = r_msip;
  assign mtip      = r_mtip;
  assign meip      = r_meip;
  assign ext_irq   = r_meip;

endmodule
